db15_serial_joy_reader: RTL and testbench
=========================================

Name: db15_serial_joy_reader

Overview:
- Upstream stage of the core top level: drives the external DB15 splitter's 74HC165 shift-register chain through the user port.
- Deserialises 32 active-low button bits per frame into two active-high 16-bit joystick words (player 1 and player 2).
- The top level consumes these words when the UserIO joystick mode is enabled.
- An optional two-frame agreement filter rejects line glitches before the words are published.

Parameters:
- CLK_DIV, 24, clk cycles per tick (one half-period of joy_clk); must be >= 2.
- GAP_TICKS, 35, idle ticks between the end of one frame and the next LOAD; must be >= 1.
- FILTER, 1, 1 = publish only when two consecutive raw frames are identical; 0 = publish every frame.

Ports:
- clk, input, 1, system clock (40-50 MHz).
- reset_n, input, 1, synchronous active-low reset.
- en, input, 1, reader enable (UserIO DB15 mode selected).
- joy_data, input, 1, serial data from the splitter, active low.
- joy_clk, output, 1, shift clock to the splitter.
- joy_load, output, 1, parallel-load strobe to the splitter, active low.
- joystick1, output, 16, player 1 buttons, active high, bit i = serial bit i.
- joystick2, output, 16, player 2 buttons, active high, bit i = serial bit 16+i.
- frame_strobe, output, 1, one-cycle pulse when joystick1/joystick2 are updated.

Behaviour:
- One clock domain: clk. Reset is synchronous and active-low (reset_n); all state updates on the rising edge of clk.
- All outputs are registered.
- Reset values: joy_clk=0, joy_load=1, joystick1=0, joystick2=0, frame_strobe=0. Internal state: state=LOAD, tick counter=0, bit counter=0, previous-frame register=0.
- Tick generator: free-running counter 0..CLK_DIV-1. A tick occurs on the cycle the counter reaches CLK_DIV-1. The counter is cleared on reset, on en=0, and on every state change.
- States:
  - LOAD: joy_load=0, joy_clk=0 for 1 tick. joy_load falls on the first clk after reset_n rises (with en=1). On the tick, go to LO.
  - LO: joy_load=1, joy_clk=0 for 1 tick. On the tick cycle, capture ~joy_data into shift bit[bitcnt]. Then go to HI.
  - HI: joy_clk=1 for 1 tick; the rising edge advances the '165. On the tick: if bitcnt=31, go to COMMIT; else bitcnt+1 and go to LO.
  - COMMIT: lasts 1 cycle.
    - FILTER=0: publish.
    - FILTER=1: publish only if raw == previous raw.
    - Always copy raw into the previous-frame register.
    - Publish means: joystick1 <= raw[15:0], joystick2 <= raw[31:16], frame_strobe=1 on the following cycle.
    - bitcnt <= 0, then go to GAP.
  - GAP: joy_clk=0, joy_load=1 for GAP_TICKS ticks, then go to LOAD.
- Frame period = (1 + 64 + GAP_TICKS) x CLK_DIV + 1 cycles. Defaults give 2401 cycles.
- frame_strobe is never asserted for more than one consecutive cycle.
- en=0 (any state, any time): next cycle forces state=LOAD, counters=0, joy_clk=0, joy_load=1, joystick1=joystick2=0, previous-frame register=0. No frame_strobe is produced.
- When en returns to 1, the sequence starts as after reset; joy_load falls on the next cycle.
- reset_n=0 mid-frame: aborts the frame and restores the reset values. A partial frame is never published.
- Filter start-up: after reset or en re-assertion the previous-frame register is 0. An all-released first frame (raw=0) therefore publishes immediately; any pressed bit needs two matching frames.
- joy_data is not synchronised inside this block; the top level provides a 2-flop synchroniser.

Test Plan:
- Reset values: hold reset_n=0 for 5 cycles → joy_clk=0, joy_load=1, joystick1=joystick2=0, frame_strobe=0. After release, joy_load=0 for exactly 24 cycles, then 32 joy_clk high pulses of 24 cycles each.
- Single frame, FILTER=0: drive joy_data so the low bits sent are bits 0, 4 and 17 (all others high) → after COMMIT, joystick1=16'h0011, joystick2=16'h0002, frame_strobe high for 1 cycle. Next strobe follows exactly 2401 cycles later.
- Filter, FILTER=1: frame A=32'h0000_0010, then frame B=32'h0000_0020, then B again → no publish after B#1. After B#2, joystick1=16'h0020 with one strobe. The published words never equal A.
- en dropped mid-frame (at bit 10): next cycle joystick words = 0, lines idle, no strobe. Re-assert en → joy_load falls the next cycle and the first full frame publishes correctly.
- Reset mid-shift (at bit 20, with joystick1 previously 16'h00FF): outputs return to reset values. The frame restarts from LOAD and 16'h00FF is not retained.
- Timing, CLK_DIV=2, GAP_TICKS=1: joy_clk period = 4 cycles, frame period = 133 cycles. Verify joy_data is sampled on the last LO cycle, before each joy_clk rising edge.

Source files
------------

// File: rtl/db15_serial_joy_reader.sv
// db15_serial_joy_reader
//   Drives the 74HC165 chain of an external DB15 joystick splitter. It
//   deserialises 32 active-low button bits per frame into two active-high
//   16-bit joystick words. An optional two-frame agreement filter holds back
//   a frame until the same raw pattern has been seen twice in a row.
//
// Ports
//   clk          in   system clock
//   reset_n      in   synchronous active-low reset
//   en           in   reader enable; low forces idle lines and cleared words
//   joy_data     in   serial data from the splitter, active low (already synchronised)
//   joy_clk      out  shift clock to the splitter
//   joy_load     out  parallel-load strobe to the splitter, active low
//   joystick1    out  player 1 buttons, bit i = serial bit i
//   joystick2    out  player 2 buttons, bit i = serial bit 16+i
//   frame_strobe out  one-cycle pulse when the joystick words are updated
module db15_serial_joy_reader #(
  parameter int CLK_DIV   = 24,
  parameter int GAP_TICKS = 35,
  parameter bit FILTER    = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic        joy_data,
  output logic        joy_clk,
  output logic        joy_load,
  output logic [15:0] joystick1,
  output logic [15:0] joystick2,
  output logic        frame_strobe
);

  localparam int TICK_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_W  = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_TICKS - 1);

  typedef enum logic [2:0] {
    S_LOAD,
    S_LO,
    S_HI,
    S_COMMIT,
    S_GAP
  } state_t;

  state_t            state_reg, state_next;
  logic              active_reg, active_next;
  logic [TICK_W-1:0] tick_cnt_reg, tick_cnt_next;
  logic [4:0]        bit_cnt_reg, bit_cnt_next;
  logic [GAP_W-1:0]  gap_cnt_reg, gap_cnt_next;
  logic [31:0]       raw_reg, raw_next;
  logic [31:0]       prev_reg, prev_next;
  logic              joy_clk_next, joy_load_next, strobe_next;
  logic [15:0]       joy1_next, joy2_next;
  logic              tick;

  assign tick = (tick_cnt_reg == TICK_LAST);

  // State register: every piece of state, including the registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg    <= S_LOAD;
      active_reg   <= 1'b0;
      tick_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      gap_cnt_reg  <= '0;
      raw_reg      <= '0;
      prev_reg     <= '0;
      joy_clk      <= 1'b0;
      joy_load     <= 1'b1;
      joystick1    <= '0;
      joystick2    <= '0;
      frame_strobe <= 1'b0;
    end else begin
      state_reg    <= state_next;
      active_reg   <= active_next;
      tick_cnt_reg <= tick_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      gap_cnt_reg  <= gap_cnt_next;
      raw_reg      <= raw_next;
      prev_reg     <= prev_next;
      joy_clk      <= joy_clk_next;
      joy_load     <= joy_load_next;
      joystick1    <= joy1_next;
      joystick2    <= joy2_next;
      frame_strobe <= strobe_next;
    end
  end

  // Next-state logic. active_reg is low for the idle cycle that follows reset
  // or an en=0 period; on the first enabled cycle the LOAD period starts with
  // a fresh tick count so joy_load stays low for a full CLK_DIV cycles.
  always_comb begin
    state_next    = state_reg;
    active_next   = 1'b1;
    tick_cnt_next = tick ? '0 : tick_cnt_reg + 1'b1;
    bit_cnt_next  = bit_cnt_reg;
    gap_cnt_next  = gap_cnt_reg;
    if (!en) begin
      state_next    = S_LOAD;
      active_next   = 1'b0;
      tick_cnt_next = '0;
      bit_cnt_next  = '0;
      gap_cnt_next  = '0;
    end else if (!active_reg) begin
      tick_cnt_next = '0;
    end else begin
      case (state_reg)
        S_LOAD: if (tick) state_next = S_LO;
        S_LO:   if (tick) state_next = S_HI;
        S_HI: begin
          if (tick) begin
            if (bit_cnt_reg == 5'd31) begin
              state_next = S_COMMIT;
            end else begin
              bit_cnt_next = bit_cnt_reg + 5'd1;
              state_next   = S_LO;
            end
          end
        end
        S_COMMIT: begin
          bit_cnt_next = '0;
          state_next   = S_GAP;
        end
        S_GAP: begin
          if (tick) begin
            if (gap_cnt_reg == GAP_LAST) begin
              gap_cnt_next = '0;
              state_next   = S_LOAD;
            end else begin
              gap_cnt_next = gap_cnt_reg + 1'b1;
            end
          end
        end
        default: state_next = S_LOAD;
      endcase
      if (state_next != state_reg) tick_cnt_next = '0;
    end
  end

  // Output logic. Line levels are decoded from state_next so the registered
  // joy_clk/joy_load line up exactly with the state they belong to.
  always_comb begin
    joy_clk_next  = 1'b0;
    joy_load_next = 1'b1;
    strobe_next   = 1'b0;
    joy1_next     = joystick1;
    joy2_next     = joystick2;
    raw_next      = raw_reg;
    prev_next     = prev_reg;
    if (!en) begin
      joy1_next = '0;
      joy2_next = '0;
      prev_next = '0;
    end else begin
      joy_clk_next  = (state_next == S_HI);
      joy_load_next = (state_next != S_LOAD);
      // Sample on the last LO cycle, just before joy_clk rises and shifts the chain.
      if (active_reg && state_reg == S_LO && tick) begin
        raw_next[bit_cnt_reg] = ~joy_data;
      end
      if (active_reg && state_reg == S_COMMIT) begin
        prev_next = raw_reg;
        if ((FILTER == 1'b0) || (raw_reg == prev_reg)) begin
          joy1_next   = raw_reg[15:0];
          joy2_next   = raw_reg[31:16];
          strobe_next = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_db15_serial_joy_reader.sv
module tb_db15_serial_joy_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n_a, en_a, reset_n_b, en_b, joy_data;
  logic        jclk_a, load_a, strobe_a, jclk_b, load_b, strobe_b;
  logic [15:0] j1_a, j2_a, j1_b, j2_b;

  // Standard timing, no filter.
  db15_serial_joy_reader #(.CLK_DIV(24), .GAP_TICKS(35), .FILTER(1'b0)) u_dut_std (
    .clk          (clk),
    .reset_n      (reset_n_a),
    .en           (en_a),
    .joy_data     (joy_data),
    .joy_clk      (jclk_a),
    .joy_load     (load_a),
    .joystick1    (j1_a),
    .joystick2    (j2_a),
    .frame_strobe (strobe_a)
  );

  // Fast timing with the agreement filter.
  db15_serial_joy_reader #(.CLK_DIV(2), .GAP_TICKS(1), .FILTER(1'b1)) u_dut_fast (
    .clk          (clk),
    .reset_n      (reset_n_b),
    .en           (en_b),
    .joy_data     (joy_data),
    .joy_clk      (jclk_b),
    .joy_load     (load_b),
    .joystick1    (j1_b),
    .joystick2    (j2_b),
    .frame_strobe (strobe_b)
  );

  // Only one reader runs at a time; sel picks which one the splitter model serves.
  logic        sel;
  logic        cur_load, cur_jclk, cur_strobe;
  logic [15:0] cur_j1, cur_j2;
  assign cur_load   = sel ? load_b   : load_a;
  assign cur_jclk   = sel ? jclk_b   : jclk_a;
  assign cur_strobe = sel ? strobe_b : strobe_a;
  assign cur_j1     = sel ? j1_b     : j1_a;
  assign cur_j2     = sel ? j2_b     : j2_a;

  int cycle_no = 0;
  always @(posedge clk) cycle_no <= cycle_no + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Splitter model: '165 chain latched while load is low, shifted on each
  // joy_clk rising edge. Pressed buttons drive the line low. During the first
  // cycle after load rises or joy_clk falls the line carries the wrong level,
  // so only a sample taken late in the low phase reads the right bit.
  logic [31:0] pressed_word;
  initial begin : splitter
    logic [31:0] latched;
    int          idx;
    logic        p_clk, p_load, glitch, b;
    latched  = '0;
    idx      = 0;
    p_clk    = 1'b0;
    p_load   = 1'b1;
    joy_data = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (!cur_load) begin
        idx     = 0;
        latched = pressed_word;
      end else if (cur_jclk && !p_clk) begin
        idx++;
      end
      glitch = (cur_load && !p_load) || (!cur_jclk && p_clk);
      p_clk  = cur_jclk;
      p_load = cur_load;
      b = (idx < 32) ? ~latched[idx[4:0]] : 1'b1;
      joy_data = glitch ? ~b : b;
    end
  end

  // Reference model: what the published words should be.
  logic [31:0] model_prev;
  logic [15:0] exp_j1, exp_j2;

  // Runs one whole frame, starting at the sample where joy_load has just fallen
  // and ending at the sample where it falls again.
  task automatic run_frame(input logic [31:0] word, input bit filt, input int div,
                           input int period, output int strobe_abs);
    bit pub, in_load, prev_s, prev_c, done;
    int cyc, load_low, pulses, bad_w, bad_p, hi_run, last_rise, strobes, dbl, strobe_cyc;
    pub = !filt || (word == model_prev);
    model_prev = word;
    if (pub) begin
      exp_j1 = word[15:0];
      exp_j2 = word[31:16];
    end
    pressed_word = word;
    in_load = 1'b1; prev_s = 1'b0; prev_c = 1'b0; done = 1'b0;
    cyc = 0; load_low = 0; pulses = 0; bad_w = 0; bad_p = 0; hi_run = 0;
    last_rise = -1; strobes = 0; dbl = 0; strobe_cyc = -1; strobe_abs = -1;
    while (!done) begin
      if (in_load) begin
        if (!cur_load) load_low++;
        else in_load = 1'b0;
      end
      if (cur_jclk) begin
        if (!prev_c) begin
          if (last_rise >= 0 && (cyc - last_rise) != 2 * div) bad_p++;
          last_rise = cyc;
        end
        hi_run++;
      end else if (hi_run > 0) begin
        pulses++;
        if (hi_run != div) bad_w++;
        hi_run = 0;
      end
      if (cur_strobe) begin
        strobes++;
        if (prev_s) dbl++;
        strobe_cyc = cyc;
        strobe_abs = cycle_no;
      end
      prev_s = cur_strobe;
      prev_c = cur_jclk;
      @(negedge clk);
      cyc++;
      if (!cur_load && !in_load) done = 1'b1;
      else if (cyc > period + 100) done = 1'b1;
    end
    check_val("load_len", load_low, div);
    check_val("clk_pulses", pulses, 32);
    check_val("clk_width_errs", bad_w, 0);
    check_val("clk_period_errs", bad_p, 0);
    check_val("frame_period", cyc, period);
    check_val("strobe_count", strobes, pub ? 1 : 0);
    check_val("strobe_double", dbl, 0);
    if (pub) check_val("strobe_pos", strobe_cyc, 65 * div + 1);
    check_val("joystick1", cur_j1, exp_j1);
    check_val("joystick2", cur_j2, exp_j2);
    $display("frame div=%0d word=%08h publish=%0d strobes=%0d j1=%04h j2=%04h period=%0d",
             div, word, pub, strobes, cur_j1, cur_j2, cyc);
  endtask

  // Aborts a frame of the fast reader after a number of joy_clk pulses, by
  // dropping en or by pulsing reset_n, then restarts it.
  task automatic abort_frame(input logic [31:0] word, input int bits, input bit use_reset);
    int rises, guard, activity;
    bit p;
    rises = 0; guard = 0; activity = 0; p = 1'b0;
    pressed_word = word;
    while (rises < bits && guard < 4000) begin
      @(negedge clk);
      guard++;
      if (cur_jclk && !p) rises++;
      p = cur_jclk;
    end
    check_val("abort_reached", rises, bits);
    if (use_reset) reset_n_b = 1'b0;
    else en_b = 1'b0;
    @(negedge clk);
    check_val("abort_jclk", cur_jclk, 1'b0);
    check_val("abort_load", cur_load, 1'b1);
    check_val("abort_j1", cur_j1, 16'h0000);
    check_val("abort_j2", cur_j2, 16'h0000);
    check_val("abort_strobe", cur_strobe, 1'b0);
    repeat (3) begin
      @(negedge clk);
      if (cur_strobe || cur_jclk || !cur_load || cur_j1 != 0 || cur_j2 != 0) activity++;
    end
    check_val("abort_idle", activity, 0);
    model_prev = '0;
    exp_j1 = '0;
    exp_j2 = '0;
    if (use_reset) reset_n_b = 1'b1;
    else en_b = 1'b1;
    @(negedge clk);
    check_val("restart_load_fall", cur_load, 1'b0);
    $display("abort %s after %0d bits word=%08h", use_reset ? "reset" : "en", bits, word);
  endtask

  initial begin : main
    int s1, s2, s;
    logic [31:0] w, last_w;
    sel = 1'b0;
    reset_n_a = 1'b0; en_a = 1'b1;
    reset_n_b = 1'b0; en_b = 1'b0;
    pressed_word = 32'h0002_0011;
    model_prev = '0; exp_j1 = '0; exp_j2 = '0;

    // Reset values of the standard reader.
    repeat (5) begin
      @(negedge clk);
      check_val("rst_jclk", cur_jclk, 1'b0);
      check_val("rst_load", cur_load, 1'b1);
      check_val("rst_j1", cur_j1, 16'h0000);
      check_val("rst_j2", cur_j2, 16'h0000);
      check_val("rst_strobe", cur_strobe, 1'b0);
    end
    reset_n_a = 1'b1;
    @(negedge clk);
    check_val("load_fall_after_reset", cur_load, 1'b0);

    // Bits 0, 4 and 17 pressed, then a random frame; no filter, both publish.
    run_frame(32'h0002_0011, 1'b0, 24, 2401, s1);
    run_frame($urandom, 1'b0, 24, 2401, s2);
    check_val("strobe_spacing", s2 - s1, 2401);
    en_a = 1'b0;
    @(negedge clk);

    // Fast reader with the filter.
    sel = 1'b1;
    en_b = 1'b1;
    repeat (3) @(negedge clk);
    reset_n_b = 1'b1;
    model_prev = '0; exp_j1 = '0; exp_j2 = '0;
    @(negedge clk);
    check_val("fast_load_fall", cur_load, 1'b0);
    run_frame(32'h0000_0010, 1'b1, 2, 133, s);
    run_frame(32'h0000_0020, 1'b1, 2, 133, s);
    run_frame(32'h0000_0020, 1'b1, 2, 133, s);

    // Random frames; about half repeat the previous pattern.
    last_w = 32'h0000_0020;
    for (int i = 0; i < 12; i++) begin
      w = $urandom;
      if ($urandom_range(0, 1) == 1) w = last_w;
      run_frame(w, 1'b1, 2, 133, s);
      last_w = w;
    end

    // en dropped at bit 10; an all-released first frame then publishes at once.
    abort_frame($urandom, 10, 1'b0);
    run_frame(32'h0000_0000, 1'b1, 2, 133, s);
    for (int i = 0; i < 4; i++) begin
      w = (i % 2 == 0) ? $urandom : last_w;
      run_frame(w, 1'b1, 2, 133, s);
      last_w = w;
    end

    // Reset at bit 20 with 16'h00FF published; the old word must not survive.
    run_frame(32'h0000_00FF, 1'b1, 2, 133, s);
    run_frame(32'h0000_00FF, 1'b1, 2, 133, s);
    check_val("pre_reset_j1", cur_j1, 16'h00FF);
    abort_frame($urandom, 20, 1'b1);
    w = $urandom | 32'h1;
    run_frame(w, 1'b1, 2, 133, s);
    run_frame(w, 1'b1, 2, 133, s);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
